imm_pipe: RTL
=============

IMM_PIPE -- requirements
Module: imm_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter STAGES, default 1, number of register stages from input to output; legal values 1..4.
REQ-003 SHALL have parameter ENABLE_CSR, default 0; when 1, format bit [6] selects the CSR zimm immediate.
REQ-004 SHALL have parameter TAG_W, default 5, width of the sideband tag carried alongside each instruction.
REQ-005 SHALL run on one clock with a synchronous, active-high reset.
REQ-006 i_clk  input  1  clock; all state updates on the rising edge.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_valid  input  1  upstream offers an instruction this cycle.
REQ-009 o_ready  output  1  block accepts the input this cycle.
REQ-010 i_inst  input  32  instruction word.
REQ-011 i_format  input  7  one-hot format: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J, [6] CSR zimm.
REQ-012 i_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-013 o_valid  output  1  output entry valid.
REQ-014 i_ready  input  1  downstream accepts the output this cycle.
REQ-015 o_immediate  output  XLEN  decoded immediate.
REQ-016 o_tag  output  TAG_W  tag of the output entry.
REQ-017 o_error  output  1  output entry had an illegal format encoding.

Function
REQ-018 Input transfer SHALL occur when i_valid && o_ready; output transfer SHALL occur when o_valid && i_ready.
REQ-019 Immediate decode SHALL be: I = inst[31:20] sign-extended; S = {inst[31:25], inst[11:7]} sign-extended; B = {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended; J = {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
REQ-020 U = {inst[31:12], 12'b0}, sign-extended from bit 31 to XLEN when XLEN=64.
REQ-021 CSR zimm = inst[19:15], zero-extended to XLEN.
REQ-022 R-type SHALL produce immediate 0 with o_error=0.
REQ-023 Illegal format SHALL be any of: i_format == 0; more than one bit set; bit [6] set with ENABLE_CSR=0. An illegal format SHALL produce immediate 0 with o_error=1, and the entry SHALL still flow through the pipeline.
REQ-024 Decode SHALL be combinational into stage 1; stages 2..STAGES SHALL be plain register copies; output SHALL be driven directly from the last stage registers.
REQ-025 Each stage k SHALL hold {valid, immediate, tag, error}.
REQ-026 Stage k SHALL load from its predecessor when ready_k = !valid_k || ready_(k+1), where ready_(STAGES+1) = i_ready and o_ready = ready_1.
REQ-027 When stage k loads and its predecessor is not valid or not transferring, valid_k SHALL clear (bubble), so bubbles collapse under backpressure.
REQ-028 With an empty pipe and i_ready=1, latency SHALL be STAGES cycles from input transfer to o_valid.
REQ-029 Under a continuous flow with i_ready held at 1, throughput SHALL be one entry per cycle.
REQ-030 Entries SHALL never be dropped, duplicated or reordered.
REQ-031 While o_valid=1 && i_ready=0, o_immediate, o_tag and o_error SHALL hold stable.
REQ-032 Capacity SHALL be STAGES entries; o_ready SHALL deassert combinationally only when all stages are valid and i_ready=0.
REQ-033 Simultaneous output transfer and input transfer in a full pipe SHALL be legal, with all stages shifting in the same cycle.

Reset
REQ-034 When i_rst=1 at a clock edge, all valid bits, immediates, tags and error bits SHALL clear to 0; o_valid=0 the cycle after.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries; an input offered during the reset cycle SHALL NOT be captured.
REQ-036 o_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-037 XLEN=32, STAGES=1: I-type 0xFFF00093 -> 0xFFFFFFFF; S-type 0xFE112E23 -> 0xFFFFFFFC; B-type 0xFE000EE3 -> 0xFFFFFFFC; U-type 0x123450B7 -> 0x12345000; J-type 0x0080006F -> 0x00000008; all with o_valid one cycle after input.
REQ-038 XLEN=64: I-type 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF; U-type 0x80000037 -> 0xFFFFFFFF80000000; ENABLE_CSR=1, format bit6, inst 0x000FD073 -> 0x000000000000001F.
REQ-039 Illegal formats: i_format = 7'b0000110 -> immediate 0, o_error=1; i_format = 0 -> o_error=1; bit6 set with ENABLE_CSR=0 -> o_error=1.
REQ-040 STAGES=3, i_ready=0: push tags 1..4 -> tags 1..3 accepted, o_ready=0 on the fourth; release i_ready -> tags 1,2,3,4 emerge in order, with o_immediate stable while stalled.
REQ-041 STAGES=2, i_valid and i_ready both held at 1 for 10 cycles -> 10 entries out, back-to-back, first at cycle 2.
REQ-042 Reset with 2 entries in flight -> o_valid=0 the next cycle, o_ready=1, and no stale entry ever emerges.

Source files
------------

// File: rtl/imm_pipe.sv
// imm_pipe -- RISC-V immediate decoder followed by an elastic register pipeline.
//
// The instruction word is decoded into a sign- or zero-extended immediate in
// the same cycle it is accepted. The result, the sideband tag and an
// illegal-format flag then travel through STAGES register stages. Each stage
// can load whenever it is empty or its successor is taking its entry, so
// bubbles collapse while the output is stalled.
//
// Parameters
//   XLEN       immediate width (32 or 64)
//   STAGES     number of register stages between input and output (1..4)
//   ENABLE_CSR 1: format bit [6] selects the CSR zimm immediate; 0: bit [6] is illegal
//   TAG_W      width of the sideband tag
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      upstream offers an instruction
//   o_ready      pipeline accepts the input this cycle
//   i_inst       32-bit instruction word
//   i_format     one-hot format: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J, [6] CSR zimm
//   i_tag        sideband tag, carried unchanged
//   o_valid      output entry valid
//   i_ready      downstream accepts the output
//   o_immediate  decoded immediate of the output entry
//   o_tag        tag of the output entry
//   o_error      output entry had an illegal format encoding
module imm_pipe #(
  parameter int XLEN       = 32,
  parameter int STAGES     = 1,
  parameter int ENABLE_CSR = 0,
  parameter int TAG_W      = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_inst,
  input  logic [6:0]       i_format,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_immediate,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_error
);

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic            w_fmt_onehot;
  logic            w_csr_illegal;
  logic            w_err;
  logic [XLEN-1:0] w_imm;
  logic            w_unused_opcode;

  // The opcode field is not needed: the format arrives pre-decoded.
  assign w_unused_opcode = ^i_inst[6:0];

  // x & (x-1) clears the lowest set bit, so a non-zero result means two or
  // more bits were set.
  assign w_fmt_onehot  = (i_format != 7'd0) && ((i_format & (i_format - 7'd1)) == 7'd0);
  assign w_csr_illegal = i_format[6] && (ENABLE_CSR == 0);

  always_comb begin
    w_imm = '0;
    w_err = 1'b0;
    if (!w_fmt_onehot || w_csr_illegal) begin
      w_err = 1'b1;
    end else if (i_format[1]) begin
      w_imm = XLEN'($signed(i_inst[31:20]));
    end else if (i_format[2]) begin
      w_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
    end else if (i_format[3]) begin
      w_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
    end else if (i_format[4]) begin
      // Upper immediate is already 32 bits wide; only XLEN=64 actually extends.
      w_imm = XLEN'($signed({i_inst[31:12], 12'b0}));
    end else if (i_format[5]) begin
      w_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
    end else if (i_format[6]) begin
      w_imm = XLEN'(i_inst[19:15]);
    end
    // R-type (bit [0]) falls through with a zero immediate and no error.
  end

  // ---------------------------------------------------------------------------
  // Stage registers, index 0 is the first stage, STAGES-1 drives the outputs
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] r_valid;
  logic [XLEN-1:0]   r_imm [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic              r_err [STAGES];

  // w_ready[k]: stage k may load this cycle; w_ready[STAGES] is the downstream.
  logic [STAGES:0] w_ready;

  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !r_valid[k] || w_ready[k+1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_imm[k] <= '0;
        r_tag[k] <= '0;
        r_err[k] <= 1'b0;
      end
    end else begin
      // A loading stage takes its predecessor's valid bit verbatim: an empty
      // predecessor becomes a bubble. Payload only moves with a real entry.
      if (w_ready[0]) begin
        r_valid[0] <= i_valid;
        if (i_valid) begin
          r_imm[0] <= w_imm;
          r_tag[0] <= i_tag;
          r_err[0] <= w_err;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_imm[k] <= r_imm[k-1];
            r_tag[k] <= r_tag[k-1];
            r_err[k] <= r_err[k-1];
          end
        end
      end
    end
  end

  assign o_ready     = w_ready[0];
  assign o_valid     = r_valid[STAGES-1];
  assign o_immediate = r_imm[STAGES-1];
  assign o_tag       = r_tag[STAGES-1];
  assign o_error     = r_err[STAGES-1];

endmodule
